// File: rtl/manual_drive_ctrl_if.sv
// Signal bundle between the car-simulator top and the manual drive controller.
// Switch/pedal levels flow to the controller; status, odometer and lamps flow back.
interface manual_drive_ctrl_if #(
  parameter int MILEAGE_W = 16
);
  logic                 power_input;
  logic                 throttle;
  logic                 clutch;
  logic                 brake;
  logic                 reverse;
  logic                 turn_left_signal;
  logic                 turn_right_signal;
  logic                 power_now;
  logic [3:0]           state;
  logic                 reverse_now;
  logic [MILEAGE_W-1:0] mileage;
  logic                 left_led;
  logic                 right_led;

  modport master (
    output power_input,
    output throttle,
    output clutch,
    output brake,
    output reverse,
    output turn_left_signal,
    output turn_right_signal,
    input  power_now,
    input  state,
    input  reverse_now,
    input  mileage,
    input  left_led,
    input  right_led
  );

  modport slave (
    input  power_input,
    input  throttle,
    input  clutch,
    input  brake,
    input  reverse,
    input  turn_left_signal,
    input  turn_right_signal,
    output power_now,
    output state,
    output reverse_now,
    output mileage,
    output left_led,
    output right_led
  );
endinterface

// File: rtl/manual_drive_ctrl.sv
// Manual-transmission drive controller: power button, drive FSM,
// gear latch, saturating odometer and blinking turn/hazard lamps.
module manual_drive_ctrl #(
  parameter int PWR_ON_CYCLES  = 10,
  parameter int PWR_OFF_CYCLES = 30,
  parameter int TICK_CYCLES    = 100,
  parameter int MILEAGE_W      = 16,
  parameter int BLINK_HALF     = 50
) (
  input logic                clk,
  input logic                rst_n,
  manual_drive_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_NS    = 2'd1,
    S_ST    = 2'd2,
    S_MOV   = 2'd3
  } state_e;

  localparam int HOLD_MAX =
    (PWR_ON_CYCLES > PWR_OFF_CYCLES) ?
    PWR_ON_CYCLES : PWR_OFF_CYCLES;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [HW-1:0] HOLD_SAT =
    HW'(HOLD_MAX);
  localparam logic [HW-1:0] ON_LAST =
    HW'(PWR_ON_CYCLES - 1);
  localparam logic [HW-1:0] OFF_LAST =
    HW'(PWR_OFF_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST =
    BW'(BLINK_HALF - 1);
  localparam logic [MILEAGE_W-1:0] MIL_MAX =
    {MILEAGE_W{1'b1}};

  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 armed_q, armed_d;
  logic                 power_q, power_d;
  logic                 rev_q, rev_d;
  logic [TW-1:0]        presc_q, presc_d;
  logic [MILEAGE_W-1:0] mil_q, mil_d;
  logic                 blink_on_q, blink_on_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 phase_q, phase_d;
  logic                 lled_q, lled_d;
  logic                 rled_q, rled_d;

  logic toggle;
  logic thr_hit;
  logic any_turn;
  logic blink_act;

  always_comb begin
    thr_hit = (state_q == S_OFF) ?
      (hold_q >= ON_LAST) :
      (hold_q >= OFF_LAST);
    toggle = bus.power_input & armed_q & thr_hit;

    hold_d = '0;
    if (bus.power_input) begin
      hold_d = (hold_q == HOLD_SAT) ?
        hold_q : hold_q + HW'(1);
    end

    armed_d = armed_q;
    if (toggle) begin
      armed_d = 1'b0;
    end else if (!bus.power_input) begin
      armed_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF: state_d = S_OFF;
      S_NS: begin
        if (bus.throttle & bus.clutch) begin
          state_d = S_ST;
        end else if (bus.throttle) begin
          state_d = S_OFF;
        end
      end
      S_ST: begin
        if (bus.brake) begin
          state_d = S_NS;
        end else if (bus.throttle & ~bus.clutch) begin
          state_d = S_MOV;
        end
      end
      S_MOV: begin
        if (bus.brake) begin
          state_d = S_NS;
        end else if (bus.clutch) begin
          state_d = S_ST;
        end else if (bus.reverse != rev_q) begin
          state_d = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase
    // The power button overrides any pedal-driven move.
    if (toggle) begin
      state_d = (state_q == S_OFF) ? S_NS : S_OFF;
    end
    power_d = (state_d != S_OFF);
  end

  always_comb begin
    rev_d = rev_q;
    if (state_q == S_NS || state_q == S_ST) begin
      rev_d = bus.reverse;
    end
    if (state_d == S_OFF) begin
      rev_d = 1'b0;
    end
  end

  always_comb begin
    presc_d = '0;
    mil_d   = mil_q;
    if (state_q == S_MOV) begin
      if (presc_q == TICK_LAST) begin
        presc_d = '0;
        if (mil_q != MIL_MAX) begin
          mil_d = mil_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + TW'(1);
      end
    end
    // Re-entering MOVING always starts a full period.
    if (state_d != S_MOV) begin
      presc_d = '0;
    end
  end

  always_comb begin
    any_turn  = bus.turn_left_signal |
                bus.turn_right_signal;
    blink_act = (state_d != S_OFF) & any_turn;
    blink_on_d = 1'b0;
    bcnt_d     = '0;
    phase_d    = 1'b0;
    if (blink_act) begin
      blink_on_d = 1'b1;
      if (!blink_on_q) begin
        // First active cycle opens a lit half-period.
        phase_d = 1'b1;
        bcnt_d  = '0;
      end else if (bcnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
        bcnt_d  = '0;
      end else begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
    lled_d = phase_d & bus.turn_left_signal;
    rled_d = phase_d & bus.turn_right_signal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      hold_q     <= '0;
      armed_q    <= 1'b1;
      power_q    <= 1'b0;
      rev_q      <= 1'b0;
      presc_q    <= '0;
      mil_q      <= '0;
      blink_on_q <= 1'b0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      lled_q     <= 1'b0;
      rled_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      armed_q    <= armed_d;
      power_q    <= power_d;
      rev_q      <= rev_d;
      presc_q    <= presc_d;
      mil_q      <= mil_d;
      blink_on_q <= blink_on_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      lled_q     <= lled_d;
      rled_q     <= rled_d;
    end
  end

  assign bus.power_now   = power_q;
  assign bus.state       = {2'b00, state_q};
  assign bus.reverse_now = rev_q;
  assign bus.mileage     = mil_q;
  assign bus.left_led    = lled_q;
  assign bus.right_led   = rled_q;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Bench for manual_drive_ctrl: directed scenarios plus
// randomized traffic against a run-length behavioural model.
module tb_manual_drive_ctrl;

  localparam int ON    = 3;
  localparam int OFF   = 5;
  localparam int TICK  = 4;
  localparam int MW    = 3;
  localparam int BLINK = 2;
  localparam int MMAX  = (1 << MW) - 1;

  logic clk;
  logic rst_n;

  manual_drive_ctrl_if #(.MILEAGE_W(MW)) bus ();

  manual_drive_ctrl #(
    .PWR_ON_CYCLES (ON),
    .PWR_OFF_CYCLES(OFF),
    .TICK_CYCLES   (TICK),
    .MILEAGE_W     (MW),
    .BLINK_HALF    (BLINK)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: time-based description of the car.
  int m_state;
  int m_hold;
  bit m_armed;
  bit m_rev;
  int m_mc;
  int m_mil;
  int m_run;
  bit m_l;
  bit m_r;

  task automatic model_reset();
    m_state = 0;
    m_hold  = 0;
    m_armed = 1'b1;
    m_rev   = 1'b0;
    m_mc    = 0;
    m_mil   = 0;
    m_run   = 0;
    m_l     = 1'b0;
    m_r     = 1'b0;
  endtask

  task automatic model_step();
    int  need;
    bit  tog;
    int  ns;
    bit  ph;
    bit  pw;
    bit  th;
    bit  cl;
    bit  br;
    bit  rv;
    bit  tl;
    bit  tr;
    pw = bus.power_input;
    th = bus.throttle;
    cl = bus.clutch;
    br = bus.brake;
    rv = bus.reverse;
    tl = bus.turn_left_signal;
    tr = bus.turn_right_signal;
    need = (m_state == 0) ? ON : OFF;
    tog  = pw && m_armed && (m_hold + 1 >= need);
    ns   = m_state;
    if (m_state == 1) begin
      if (th && cl) ns = 2;
      else if (th) ns = 0;
    end else if (m_state == 2) begin
      if (br) ns = 1;
      else if (th && !cl) ns = 3;
    end else if (m_state == 3) begin
      if (br) ns = 1;
      else if (cl) ns = 2;
      else if (rv != m_rev) ns = 0;
    end
    if (tog) ns = (m_state == 0) ? 1 : 0;
    if (pw) begin
      if (m_hold < 1000) m_hold++;
    end else begin
      m_hold = 0;
    end
    if (tog) m_armed = 1'b0;
    else if (!pw) m_armed = 1'b1;
    if (m_state == 1 || m_state == 2) m_rev = rv;
    if (ns == 0) m_rev = 1'b0;
    if (m_state == 3) begin
      m_mc++;
      if (m_mc == TICK) begin
        m_mc = 0;
        if (m_mil < MMAX) m_mil++;
      end
    end
    if (ns != 3) m_mc = 0;
    if (ns != 0 && (tl || tr)) begin
      ph = ((m_run / BLINK) % 2) == 0;
      m_run++;
    end else begin
      ph    = 1'b0;
      m_run = 0;
    end
    m_l     = ph & tl;
    m_r     = ph & tr;
    m_state = ns;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic press(input int n);
    bus.power_input = 1'b1;
    repeat (n) cyc();
    bus.power_input = 1'b0;
    cyc();
  endtask

  task automatic go_moving();
    press(ON);
    bus.throttle = 1'b1;
    bus.clutch   = 1'b1;
    cyc();
    bus.clutch   = 1'b0;
    cyc();
    bus.throttle = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst_n = 1'b1;
    bus.power_input       = 1'b0;
    bus.throttle          = 1'b0;
    bus.clutch            = 1'b0;
    bus.brake             = 1'b0;
    bus.reverse           = 1'b0;
    bus.turn_left_signal  = 1'b0;
    bus.turn_right_signal = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    got = {bus.power_now, bus.state,
           bus.reverse_now, bus.mileage,
           bus.left_led, bus.right_led};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL reset_in: got %h want 0", got);
    end
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    got = {bus.power_now, bus.state,
           bus.reverse_now, bus.mileage,
           bus.left_led, bus.right_led};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL reset_out: got %h want 0", got);
    end
  endtask

  task automatic test_power_hold();
    bus.power_input = 1'b1;
    repeat (ON - 1) cyc();
    bus.power_input = 1'b0;
    cyc();
    checks++;
    if (bus.power_now !== 1'b0) begin
      errors++;
      $display("FAIL short_hold: pwr %b want 0",
               bus.power_now);
    end
    bus.power_input = 1'b1;
    repeat (ON - 1) cyc();
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL on_early: state %0d want 0",
               bus.state);
    end
    cyc();
    checks++;
    if (bus.state !== 4'd1 || bus.power_now !== 1'b1) begin
      errors++;
      $display("FAIL on: state %0d pwr %b want 1 1",
               bus.state, bus.power_now);
    end
    repeat (10) cyc();
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL no_retoggle: state %0d want 1",
               bus.state);
    end
    bus.power_input = 1'b0;
    cyc();
    bus.power_input = 1'b1;
    repeat (OFF - 1) cyc();
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL off_early: state %0d want 1",
               bus.state);
    end
    cyc();
    checks++;
    if (bus.state !== 4'd0 || bus.power_now !== 1'b0) begin
      errors++;
      $display("FAIL off: state %0d pwr %b want 0 0",
               bus.state, bus.power_now);
    end
    bus.power_input = 1'b0;
    cyc();
  endtask

  task automatic test_drive();
    press(ON);
    bus.throttle = 1'b1;
    bus.clutch   = 1'b1;
    cyc();
    checks++;
    if (bus.state !== 4'd2) begin
      errors++;
      $display("FAIL starting: state %0d want 2",
               bus.state);
    end
    bus.clutch = 1'b0;
    cyc();
    checks++;
    if (bus.state !== 4'd3) begin
      errors++;
      $display("FAIL moving: state %0d want 3",
               bus.state);
    end
    bus.throttle = 1'b0;
    repeat (TICK) cyc();
    checks++;
    if (bus.mileage !== 3'd1) begin
      errors++;
      $display("FAIL mile1: mileage %0d want 1",
               bus.mileage);
    end
    repeat (TICK) cyc();
    checks++;
    if (bus.mileage !== 3'd2) begin
      errors++;
      $display("FAIL mile2: mileage %0d want 2",
               bus.mileage);
    end
    repeat (40) cyc();
    checks++;
    if (bus.mileage !== 3'd7) begin
      errors++;
      $display("FAIL mile_sat: mileage %0d want 7",
               bus.mileage);
    end
  endtask

  task automatic test_stall();
    bus.brake = 1'b1;
    cyc();
    bus.brake = 1'b0;
    checks++;
    if (bus.state !== 4'd1) begin
      errors++;
      $display("FAIL brake: state %0d want 1",
               bus.state);
    end
    bus.throttle = 1'b1;
    cyc();
    bus.throttle = 1'b0;
    checks++;
    if (bus.state !== 4'd0 || bus.power_now !== 1'b0 ||
        bus.mileage !== 3'd7) begin
      errors++;
      $display("FAIL stall: st %0d pw %b mi %0d want 0 0 7",
               bus.state, bus.power_now, bus.mileage);
    end
  endtask

  task automatic test_gear();
    go_moving();
    bus.reverse = 1'b1;
    cyc();
    checks++;
    if (bus.state !== 4'd0 || bus.reverse_now !== 1'b0) begin
      errors++;
      $display("FAIL gear_dmg: st %0d rv %b want 0 0",
               bus.state, bus.reverse_now);
    end
    bus.reverse = 1'b0;
    go_moving();
    bus.reverse = 1'b1;
    bus.brake   = 1'b1;
    cyc();
    bus.brake = 1'b0;
    checks++;
    if (bus.state !== 4'd1 || bus.power_now !== 1'b1 ||
        bus.reverse_now !== 1'b0) begin
      errors++;
      $display("FAIL gear_brk: st %0d pw %b rv %b want 1 1 0",
               bus.state, bus.power_now, bus.reverse_now);
    end
    cyc();
    checks++;
    if (bus.reverse_now !== 1'b1) begin
      errors++;
      $display("FAIL gear_load: rv %b want 1",
               bus.reverse_now);
    end
  endtask

  task automatic test_indicators();
    bit e;
    bus.turn_left_signal = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      e = ((i / BLINK) % 2) == 0;
      checks++;
      if ({bus.left_led, bus.right_led} !== {e, 1'b0}) begin
        errors++;
        $display("FAIL left_blink[%0d]: got %b%b want %b0",
                 i, bus.left_led, bus.right_led, e);
      end
    end
    bus.turn_left_signal = 1'b0;
    cyc();
    checks++;
    if ({bus.left_led, bus.right_led} !== 2'b00) begin
      errors++;
      $display("FAIL idle_led: got %b%b want 00",
               bus.left_led, bus.right_led);
    end
    bus.turn_left_signal  = 1'b1;
    bus.turn_right_signal = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      e = ((i / BLINK) % 2) == 0;
      checks++;
      if ({bus.left_led, bus.right_led} !== {e, e}) begin
        errors++;
        $display("FAIL hazard[%0d]: got %b%b want %b%b",
                 i, bus.left_led, bus.right_led, e, e);
      end
    end
    bus.power_input = 1'b1;
    repeat (OFF) cyc();
    bus.power_input = 1'b0;
    checks++;
    if (bus.state !== 4'd0 ||
        {bus.left_led, bus.right_led} !== 2'b00) begin
      errors++;
      $display("FAIL led_off: st %0d led %b%b want 0 00",
               bus.state, bus.left_led, bus.right_led);
    end
    bus.turn_left_signal  = 1'b0;
    bus.turn_right_signal = 1'b0;
    cyc();
  endtask

  task automatic test_async_reset();
    logic [10:0] got;
    bus.reverse = 1'b0;
    go_moving();
    bus.turn_left_signal = 1'b1;
    repeat (3) cyc();
    checks++;
    if (bus.state !== 4'd3 || bus.mileage !== 3'd7) begin
      errors++;
      $display("FAIL pre_rst: st %0d mi %0d want 3 7",
               bus.state, bus.mileage);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = {bus.power_now, bus.state,
           bus.reverse_now, bus.mileage,
           bus.left_led, bus.right_led};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL async_rst: got %h want 0", got);
    end
    bus.turn_left_signal = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    logic [10:0] got;
    logic [10:0] exp;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0)
        bus.power_input = ~bus.power_input;
      bus.throttle = 1'($urandom_range(1));
      bus.clutch   = 1'($urandom_range(1));
      bus.brake    = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0)
        bus.reverse = ~bus.reverse;
      if ($urandom_range(7) == 0)
        bus.turn_left_signal = ~bus.turn_left_signal;
      if ($urandom_range(7) == 0)
        bus.turn_right_signal = ~bus.turn_right_signal;
      cyc();
      got = {bus.power_now, bus.state,
             bus.reverse_now, bus.mileage,
             bus.left_led, bus.right_led};
      exp = {m_state != 0, 4'(m_state), m_rev,
             3'(m_mil), m_l, m_r};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h",
                 i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_hold();
    test_drive();
    test_stall();
    test_gear();
    test_indicators();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
